// File: rtl/swing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swing_pkg
// Description : Shared types and coordinate moduli for the swing detector
//               and the hand position source.
// Revision    : 1.0 - initial release
// ============================================================================
package swing_pkg;

   // Coordinate moduli shared with the hand position source
   localparam int HAND_MAX_X = 3400;
   localparam int HAND_MAX_Y = 3400;
   localparam int HAND_MAX_Z = 500;

   typedef enum logic [1:0] {
      SWING_LEFT  = 2'd0,
      SWING_RIGHT = 2'd1,
      SWING_UP    = 2'd2,
      SWING_DOWN  = 2'd3
   } swing_dir_t;

   typedef enum logic [1:0] {
      ST_PRIME    = 2'd0,
      ST_ARMED    = 2'd1,
      ST_PENDING  = 2'd2,
      ST_COOLDOWN = 2'd3
   } swing_state_t;

   // Magnitude of a wrapped delta; wrapped deltas never exceed MAX/2, so 12 bits suffice
   function automatic logic [11:0] abs_delta(input logic signed [12:0] d);
      logic signed [12:0] n;
      n = -d;
      return d[12] ? n[11:0] : d[11:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_delta.sv
`default_nettype none
// ============================================================================
// Module      : wrap_delta
// Description : Shortest signed distance between two coordinates on a ring
//               of size MAX; result lies in (-MAX/2, MAX/2].
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_delta #(
   parameter int MAX = 3400
) (
   input  logic        [11:0] cur,
   input  logic        [11:0] prev,
   output logic signed [12:0] delta
);

   // 14-bit working width keeps the raw difference and the correction overflow-free
   localparam logic signed [13:0] HALF = 14'(MAX / 2);
   localparam logic signed [13:0] MODV = 14'(MAX);

   logic signed [13:0] raw;
   logic signed [13:0] adj;

   // Fold the raw difference into the half-open window around zero
   always_comb begin
      raw = $signed({2'b00, cur}) - $signed({2'b00, prev});
      adj = raw;
      if (raw > HALF) begin
         adj = raw - MODV;
      end else if (raw <= -HALF) begin
         adj = raw + MODV;
      end
      delta = adj[12:0];
   end

endmodule
`default_nettype wire

// File: rtl/swing_detector.sv
`default_nettype none
// ============================================================================
// Module      : swing_detector
// Description : Samples the hand tip position every SAMPLE_PERIOD cycles,
//               classifies large wrap-aware motions as left/right/up/down
//               swings and hands them out over valid/ready with a cooldown.
//               Optional macro SWING_DROP_CNT_EN adds a saturating count of
//               qualifying motions lost while an event was pending.
// Revision    : 1.0 - initial release
// ============================================================================
module swing_detector
   import swing_pkg::*;
#(
   parameter int SAMPLE_PERIOD    = 1625000,
   parameter int THRESH           = 48,
   parameter int COOLDOWN_SAMPLES = 8,
   parameter int MAX_X            = HAND_MAX_X,
   parameter int MAX_Y            = HAND_MAX_Y
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [11:0] hand_x_top,
   input  logic [11:0] hand_y_top,
   output logic        swing_valid,
   input  logic        swing_ready,
   output logic [1:0]  swing_dir,
   output logic [11:0] swing_mag
`ifdef SWING_DROP_CNT_EN
   ,
   output logic [7:0]  drop_count
`endif
);

   localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int CD_W  = (COOLDOWN_SAMPLES > 0) ? $clog2(COOLDOWN_SAMPLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
   localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_SAMPLES);
   localparam logic [11:0]      THRESH_V = 12'(THRESH);

   swing_state_t       state, state_next;
   logic [CNT_W-1:0]   tick_cnt;
   logic [CD_W-1:0]    cooldown;
   logic [11:0]        prev_x, prev_y;
   logic               tick;
   logic signed [12:0] dx, dy;
   logic [11:0]        ax, ay, dom_mag;
   logic               horiz, qualify;
   swing_dir_t         dir_new;
   logic               load_event, accept, cd_dec;

   wrap_delta #(.MAX(MAX_X)) u_dx (.cur(hand_x_top), .prev(prev_x), .delta(dx));
   wrap_delta #(.MAX(MAX_Y)) u_dy (.cur(hand_y_top), .prev(prev_y), .delta(dy));

   assign tick = (tick_cnt == CNT_LAST);

   // Classify the current motion: ties between axes resolve to horizontal
   always_comb begin
      ax      = abs_delta(dx);
      ay      = abs_delta(dy);
      horiz   = (ax >= ay);
      dom_mag = horiz ? ax : ay;
      qualify = (dom_mag >= THRESH_V);
      if (horiz) begin
         dir_new = dx[12] ? SWING_LEFT : SWING_RIGHT;
      end else begin
         dir_new = dy[12] ? SWING_UP : SWING_DOWN;
      end
   end

   // Next-state and control strobes
   always_comb begin
      state_next = state;
      load_event = 1'b0;
      accept     = 1'b0;
      cd_dec     = 1'b0;
      case (state)
         ST_PRIME: begin
            if (tick) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (tick && qualify) begin
               load_event = 1'b1;
               state_next = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // A tick coinciding with the handshake is simply not looked at here
            if (swing_valid && swing_ready) begin
               accept     = 1'b1;
               state_next = (COOLDOWN_SAMPLES == 0) ? ST_ARMED : ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            if (tick) begin
               cd_dec = 1'b1;
               if (cooldown == CD_W'(1)) state_next = ST_ARMED;
            end
         end
         default: state_next = ST_PRIME;
      endcase
   end

   // State register
   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= ST_PRIME;
      else         state <= state_next;
   end

   // Sample timer, previous position, event payload and cooldown counter
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         tick_cnt    <= '0;
         prev_x      <= '0;
         prev_y      <= '0;
         cooldown    <= '0;
         swing_valid <= 1'b0;
         swing_dir   <= 2'd0;
         swing_mag   <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         if (tick) begin
            prev_x <= hand_x_top;
            prev_y <= hand_y_top;
         end
         if (load_event) begin
            swing_dir <= dir_new;
            swing_mag <= dom_mag;
         end
         swing_valid <= (state_next == ST_PENDING);
         if (accept)      cooldown <= CD_LOAD;
         else if (cd_dec) cooldown <= cooldown - CD_W'(1);
      end
   end

`ifdef SWING_DROP_CNT_EN
   // Saturating count of qualifying motions lost while an event waits
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         drop_count <= '0;
      end else if (state == ST_PENDING && tick && qualify && drop_count != 8'hFF) begin
         drop_count <= drop_count + 8'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_swing_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_swing_detector
// Description : Self-checking bench for swing_detector with a behavioural
//               reference model compared every cycle, directed scenarios
//               with literal expectations, then randomized motion.
//               Honours SWING_DROP_CNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_swing_detector;

   localparam int P  = 4;
   localparam int TH = 48;
   localparam int CD = 2;
   localparam int MX = 3400;
   localparam int MY = 3400;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [11:0] hand_x_top = 12'd0;
   logic [11:0] hand_y_top = 12'd0;
   logic        swing_ready = 1'b0;
   logic        swing_valid;
   logic [1:0]  swing_dir;
   logic [11:0] swing_mag;
`ifdef SWING_DROP_CNT_EN
   logic [7:0]  drop_count;
`endif

   swing_detector #(
      .SAMPLE_PERIOD(P), .THRESH(TH), .COOLDOWN_SAMPLES(CD), .MAX_X(MX), .MAX_Y(MY)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .hand_x_top(hand_x_top),
      .hand_y_top(hand_y_top),
      .swing_valid(swing_valid),
      .swing_ready(swing_ready),
      .swing_dir(swing_dir),
      .swing_mag(swing_mag)
`ifdef SWING_DROP_CNT_EN
      ,
      .drop_count(drop_count)
`endif
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0=priming, 1=watching, 2=holding event, 3=cooling
   int m_mode = 0, m_cnt = 0, m_px = 0, m_py = 0, m_cd = 0, m_drop = 0;
   int m_dir = 0, m_mag = 0, m_valid = 0;

   // Shortest signed ring distance, result in (-mx/2, mx/2]
   function automatic int wrapd(input int cur, input int prev, input int mx);
      int m;
      m = ((cur - prev) % mx + mx) % mx;
      return (m > mx / 2) ? m - mx : m;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int dx, dy, ax, ay, dom;
      bit tick, horiz, q;
      if (!rst_in) begin
         m_mode = 0; m_cnt = 0; m_px = 0; m_py = 0; m_cd = 0; m_drop = 0;
         m_dir = 0; m_mag = 0; m_valid = 0;
      end else begin
         tick  = (m_cnt == P - 1);
         m_cnt = tick ? 0 : m_cnt + 1;
         dx    = wrapd(int'(hand_x_top), m_px, MX);
         dy    = wrapd(int'(hand_y_top), m_py, MY);
         ax    = iabs(dx);
         ay    = iabs(dy);
         horiz = (ax >= ay);
         dom   = horiz ? ax : ay;
         q     = (dom >= TH);
         case (m_mode)
            0: if (tick) m_mode = 1;
            1: if (tick && q) begin
                  m_valid = 1;
                  m_mag   = dom;
                  m_dir   = horiz ? ((dx < 0) ? 0 : 1) : ((dy < 0) ? 2 : 3);
                  m_mode  = 2;
               end
            2: begin
                  if (tick && q && m_drop < 255) m_drop++;
                  if (swing_ready) begin
                     m_valid = 0;
                     if (CD == 0) m_mode = 1;
                     else begin
                        m_cd   = CD;
                        m_mode = 3;
                     end
                  end
               end
            default: if (tick) begin
                  m_cd--;
                  if (m_cd == 0) m_mode = 1;
               end
         endcase
         if (tick) begin
            m_px = int'(hand_x_top);
            m_py = int'(hand_y_top);
         end
      end
   endtask

   task automatic compare_all();
      chk("model_valid", int'(swing_valid), m_valid);
      chk("model_dir", int'(swing_dir), m_dir);
      chk("model_mag", int'(swing_mag), m_mag);
`ifdef SWING_DROP_CNT_EN
      chk("model_drop", int'(drop_count), m_drop);
`endif
   endtask

   // One clock: model advances on the edge, outputs compared just after it
   task automatic step();
      @(posedge clk_in);
      #1;
      model_step();
      compare_all();
      @(negedge clk_in);
   endtask

   // Hold a position for exactly one sample period (one tick)
   task automatic sample(input int x, input int y);
      hand_x_top = 12'(x);
      hand_y_top = 12'(y);
      repeat (P) step();
   endtask

   int rx, ry;

   initial begin
      // Reset
      rst_in = 1'b0;
      repeat (3) step();
      chk("reset_valid", int'(swing_valid), 0);
      chk("reset_mag", int'(swing_mag), 0);
      chk("reset_dir", int'(swing_dir), 0);
      rst_in = 1'b1;

      // Stationary hand: no events
      repeat (10) sample(1800, 1800);
      chk("idle_valid", int'(swing_valid), 0);

      // Right swing, accepted immediately
      swing_ready = 1'b1;
      sample(1850, 1810);
      chk("right_valid", int'(swing_valid), 1);
      chk("right_dir", int'(swing_dir), 1);
      chk("right_mag", int'(swing_mag), 50);
      step();
      chk("right_deassert", int'(swing_valid), 0);
      repeat (P - 1) step();

      // Two cooldown ticks, then wrapped upward move
      sample(1850, 16);
      chk("cool1_valid", int'(swing_valid), 0);
      sample(1850, 16);
      sample(1897, 3360);
      chk("wrap_valid", int'(swing_valid), 1);
      chk("wrap_dir", int'(swing_dir), 2);
      chk("wrap_mag", int'(swing_mag), 56);
      step();
      repeat (P - 1) step();
      sample(1897, 3360);
      sample(1897, 3360);
      sample(1944, 3360);
      chk("small_move_valid", int'(swing_valid), 0);

      // Tie goes horizontal; held under back-pressure with a dropped move
      swing_ready = 1'b0;
      sample(1884, 20);
      chk("tie_valid", int'(swing_valid), 1);
      chk("tie_dir", int'(swing_dir), 0);
      chk("tie_mag", int'(swing_mag), 60);
      sample(1984, 20);
      repeat (4) begin
         chk("hold_valid", int'(swing_valid), 1);
         chk("hold_dir", int'(swing_dir), 0);
         chk("hold_mag", int'(swing_mag), 60);
         sample(1984, 20);
      end
`ifdef SWING_DROP_CNT_EN
      chk("drop_count", int'(drop_count), 1);
`endif

      // Accept, then cooldown swallows two qualifying ticks
      swing_ready = 1'b1;
      sample(2084, 20);
      chk("cd_block1", int'(swing_valid), 0);
      sample(2184, 20);
      chk("cd_block2", int'(swing_valid), 0);
      swing_ready = 1'b0;
      sample(2284, 20);
      chk("cd_fire_valid", int'(swing_valid), 1);
      chk("cd_fire_mag", int'(swing_mag), 100);

      // Reset while an event is pending
      rst_in = 1'b0;
      step();
      chk("midreset_valid", int'(swing_valid), 0);
      chk("midreset_mag", int'(swing_mag), 0);
      step();
      rst_in = 1'b1;
      sample(2400, 20);
      chk("post_reset_prime", int'(swing_valid), 0);
      sample(2500, 20);
      chk("post_reset_detect", int'(swing_valid), 1);
      chk("post_reset_dir", int'(swing_dir), 1);

      // Randomized motion, handshake and occasional reset
      rx = 2500;
      ry = 20;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 30) begin
            rx = (rx + int'($urandom_range(0, 300)) - 150 + MX) % MX;
            ry = (ry + int'($urandom_range(0, 300)) - 150 + MY) % MY;
         end
         if ($urandom_range(0, 199) == 0) begin
            rx = int'($urandom_range(0, MX - 1));
            ry = int'($urandom_range(0, MY - 1));
         end
         hand_x_top  = 12'(rx);
         hand_y_top  = 12'(ry);
         swing_ready = ($urandom_range(0, 3) != 0);
         rst_in      = ($urandom_range(0, 499) != 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
